// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt controller.
package irq_pkg;

    typedef enum logic {
        IRQ_IDLE   = 1'b0,
        IRQ_ACTIVE = 1'b1
    } irq_state_e;

    localparam int MAX_IRQ = 32;

    // Lowest set index of vec; 0 when vec is all zero.
    function automatic int prio_first(input logic [MAX_IRQ-1:0] vec);
        prio_first = 0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) prio_first = i;
        end
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Request/acknowledge bundle between IRQ sources, the CPU agent and irq_ctrl.
interface irq_ctrl_if #(
    parameter int NUM_IRQ = 8
);
    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] mask;
    logic               mode_wr;
    logic [NUM_IRQ-1:0] mode_din;
    logic               ack;
    logic               irq;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] overrun;

    modport master (
        output irq_in, mask, mode_wr, mode_din, ack,
        input  irq, irq_id, pending, overrun
    );

    modport slave (
        input  irq_in, mask, mode_wr, mode_din, ack,
        output irq, irq_id, pending, overrun
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: lowest set bit of vec wins.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int  WIDTH = 8,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [MAX_IRQ-1:0] vec_ext;

    always_comb begin
        vec_ext            = '0;
        vec_ext[WIDTH-1:0] = vec;
    end

    assign any = |vec;
    assign idx = IDX_W'(prio_first(vec_ext));

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-channel edge/level capture, mask, pending/overrun
// tracking and a two-state service FSM that holds one winner until ack.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int               NUM_IRQ      = 8,
    parameter logic [NUM_IRQ-1:0] EDGE_DEFAULT = '0
) (
    input logic       clk,
    input logic       rst,
    irq_ctrl_if.slave bus
);

    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    irq_state_e         state;
    irq_state_e         state_nxt;

    logic [NUM_IRQ-1:0] prev_in;
    logic [NUM_IRQ-1:0] mode_reg;
    logic [NUM_IRQ-1:0] mode_req;
    logic [NUM_IRQ-1:0] mode_req_nxt;
    logic [NUM_IRQ-1:0] mode_nxt;
    logic [NUM_IRQ-1:0] mode_chg;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] overrun_q;
    logic [NUM_IRQ-1:0] pend_nxt;
    logic [NUM_IRQ-1:0] ovr_nxt;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] req;
    logic [NUM_IRQ-1:0] lock;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] hold;
    logic [NUM_IRQ-1:0] edge_pend;
    logic [NUM_IRQ-1:0] lvl_pend;

    logic               any;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    id_q;
    logic               grant;
    logic               clear_en;

    assign rise = bus.irq_in & ~prev_in;
    assign req  = pending_q & ~bus.mask;

    irq_prio_enc #(
        .WIDTH (NUM_IRQ)
    ) u_enc (
        .vec (req),
        .any (any),
        .idx (win)
    );

    // The channel in service is locked: its mode change waits for ack and
    // a level channel's pending bit is frozen until then.
    assign lock = (state == IRQ_ACTIVE) ? (NUM_IRQ'(1) << id_q) : '0;
    assign clr  = clear_en ? lock : '0;
    assign hold = lock & ~clr;

    always_comb begin
        mode_req_nxt = bus.mode_wr ? bus.mode_din : mode_req;
        mode_nxt     = (mode_reg & lock) | (mode_req_nxt & ~lock);
        mode_chg     = mode_nxt ^ mode_reg;

        // A new edge coincident with ack wins over the clear.
        edge_pend    = (pending_q & ~clr) | rise;
        lvl_pend     = (hold & pending_q) | (~hold & bus.irq_in);
        pend_nxt     = ((mode_reg & edge_pend) | (~mode_reg & lvl_pend)) & ~mode_chg;
        ovr_nxt      = (overrun_q | (mode_reg & rise & pending_q)) & ~clr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IRQ_IDLE;
            id_q      <= '0;
            prev_in   <= '0;
            mode_reg  <= EDGE_DEFAULT;
            mode_req  <= EDGE_DEFAULT;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            state     <= state_nxt;
            prev_in   <= bus.irq_in;
            mode_reg  <= mode_nxt;
            mode_req  <= mode_req_nxt;
            pending_q <= pend_nxt;
            overrun_q <= ovr_nxt;
            if (grant) id_q <= win;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IRQ_IDLE:   if (any)     state_nxt = IRQ_ACTIVE;
            IRQ_ACTIVE: if (bus.ack) state_nxt = IRQ_IDLE;
            default:                 state_nxt = IRQ_IDLE;
        endcase
    end

    always_comb begin
        bus.irq  = (state == IRQ_ACTIVE);
        grant    = (state == IRQ_IDLE) && any;
        clear_en = (state == IRQ_ACTIVE) && bus.ack;
    end

    assign bus.irq_id  = id_q;
    assign bus.pending = pending_q;
    assign bus.overrun = overrun_q;

endmodule
